// File: rtl/pkt_source_gen.sv
// Per-port traffic source: LFSR-driven injection decision, destination selection
// (uniform / hotspot / stream) and a first-word-fall-through queue toward the network.
module pkt_source_gen #(
   parameter int unsigned PORT_NO = 0,
   parameter int unsigned PORTS   = 16,
   parameter int unsigned DEST_W  = $clog2(PORTS),
   parameter int unsigned TS_W    = 30,
   parameter int unsigned DEPTH   = 16,
   parameter logic [31:0] SEED    = 32'hACE10001
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [TS_W-1:0]   timestamp,
   input  logic [1:0]        mode,
   input  logic [15:0]       rate,
   input  logic [7:0]        hot_frac,
   input  logic [DEST_W-1:0] hot_dest,
   input  logic [TS_W-1:0]   warmup,
   input  logic              net_full,
   output logic              pkt_valid,
   output logic [DEST_W-1:0] pkt_dest,
   output logic [DEST_W-1:0] pkt_source,
   output logic [TS_W-1:0]   pkt_data,
   output logic              fifo_overflow,
   output logic [31:0]       gen_count,
   output logic [15:0]       drop_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [31:0] SEED_MIX  = SEED ^ 32'(PORT_NO + 1);
   localparam logic [31:0] SEED_INIT = (SEED_MIX == 32'd0) ? 32'd1 : SEED_MIX;
   // Feedback terms x^22 + x^2 + x + 1 of the degree-32 polynomial
   localparam logic [31:0] TAPS      = 32'h0040_0007;
   localparam logic [DEST_W-1:0] LAST = DEST_W'(PORTS - 1);
   localparam logic [DEST_W-1:0] SELF = DEST_W'(PORT_NO);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [31:0]       lfsr;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [DEST_W-1:0] mem_dest [DEPTH];
   logic [TS_W-1:0]   mem_ts   [DEPTH];

   logic [DEST_W-1:0] r_sel;
   logic [DEST_W-1:0] d_fold;
   logic [DEST_W-1:0] uni_dest;
   logic [DEST_W-1:0] dest;
   logic              gen;
   logic              empty;
   logic              full;
   logic              pop;
   logic              push;
   logic              drop;

   // Injection decision and destination for the current cycle
   always_comb begin
      r_sel    = lfsr[16 +: DEST_W];
      d_fold   = (r_sel >= LAST) ? r_sel - LAST : r_sel;
      uni_dest = (d_fold >= SELF) ? d_fold + DEST_W'(1) : d_fold;
      dest     = uni_dest;
      gen      = (mode != 2'd0) && (timestamp >= warmup) && (lfsr[15:0] < rate);
      case (mode)
         2'd2: begin
            if ((lfsr[31:24] < hot_frac) && (hot_dest != SELF)) dest = hot_dest;
         end
         2'd3: begin
            dest = hot_dest;
            if (hot_dest == SELF) gen = 1'b0;
         end
         default: ;
      endcase
   end

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);
   assign pop   = !empty && !net_full;
   assign push  = gen && (!full || pop);
   assign drop  = gen && full && !pop;

   assign pkt_valid  = pop;
   assign pkt_dest   = mem_dest[rd_ptr];
   assign pkt_data   = mem_ts[rd_ptr];
   assign pkt_source = SELF;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr          <= SEED_INIT;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         gen_count     <= '0;
         drop_count    <= '0;
         fifo_overflow <= 1'b0;
      end else begin
         lfsr <= {lfsr[30:0], 1'b0} ^ (lfsr[31] ? TAPS : 32'd0);
         if (push) begin
            wr_ptr    <= wr_ptr + AW'(1);
            gen_count <= gen_count + 32'd1;
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
         if (drop) begin
            fifo_overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end
      end
   end

   // Queue storage needs no reset; occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         mem_dest[wr_ptr] <= dest;
         mem_ts[wr_ptr]   <= timestamp;
      end
   end

endmodule
